inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Instruction-fetch stage directly upstream of the 4-register add/sub/and pipeline.
- Buffers 8-bit instructions (op[7:6], rs1[5:4], rs2[3:2], rd[1:0]) pushed by a host or testbench over a valid/ready port.
- Issues one instruction per cycle on a registered inst_out, and drives the pipeline's global advance enable, start_out, which connects to the pipeline's __START__.
- Inserts NOP bubbles when starved, and drains the pipeline after a program's last instruction so that the final register write lands before done asserts.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2.
- AW, 3, log2(DEPTH).
- DRAIN_CYCLES, 2, NOP cycles issued after the last instruction (ID->EX->WB depth).
- NOP_INST, 8'h00, encoding issued as a bubble.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  host push request
- in_inst  in  8  instruction to push
- in_last  in  1  marks the pushed instruction as the last of its program
- in_ready  out  1  FIFO can accept a push (count < DEPTH)
- go  in  1  level run-enable
- inst_out  out  8  registered instruction to the pipeline ID stage
- start_out  out  1  registered pipeline advance enable
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- fifo_count  out  AW+1  current occupancy
- issued_cnt  out  16  real (non-bubble) instructions issued; wraps at 16'hFFFF->0

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On reset: state=IDLE, FIFO emptied, fifo_count=0, inst_out=NOP_INST, start_out=0, issued_cnt=0, done=0, busy=0, drain counter=0.
  - Reset mid-RUN/DRAIN discards all queued entries; in-flight pipeline state is the pipeline's own concern, since it shares rst.
- FIFO: DEPTH x 9 bits {last, inst}.
  - Push when in_valid && in_ready.
  - in_ready = (fifo_count != DEPTH); it does not consider a same-cycle pop.
  - Push and pop in the same cycle leave the count unchanged.
  - Pushes are accepted in every state.
  - Pointers wrap modulo DEPTH.
  - No bypass: an entry pushed at edge t is first poppable in the cycle after edge t.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start_out<=0, inst_out held. go=1 -> RUN.
  - RUN, go=1, FIFO non-empty: pop head; inst_out<=head.inst; start_out<=1; issued_cnt++. If head.last=1 -> DRAIN and drain_cnt<=DRAIN_CYCLES.
  - RUN, go=1, FIFO empty: inst_out<=NOP_INST; start_out<=1 (bubble); stay in RUN.
  - RUN or DRAIN, go=0: start_out<=0; inst_out held; no pop; drain_cnt frozen; state held (pause). The pipeline freezes while __START__ is low.
  - DRAIN, go=1: inst_out<=NOP_INST; start_out<=1; drain_cnt--. When drain_cnt==1 at that edge -> DONE.
  - DRAIN_CYCLES=0: the last instruction goes directly to DONE.
  - DONE: start_out<=0; inst_out<=NOP_INST; done=1.
    - go=1 -> RUN: resumes the next program already queued; done clears.
    - go=0 -> stays in DONE.
- Latency: go rising in IDLE with a non-empty FIFO -> the head appears on inst_out with start_out=1 after 2 edges (one edge IDLE->RUN, one edge pop).
- After the last instruction is issued, the pipeline commits it by the end of the DRAIN cycles; done then guarantees register file visibility.
- busy and done are combinational from state.
- fifo_count is exact at every cycle.

Optional Feature:
- Macro: INST_FETCH_STATS_EN.
- Defined: adds output port bubble_cnt[15:0]:
  - Reset 0.
  - Increments on every RUN edge with go=1 and FIFO empty.
  - Saturates at 16'hFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: hold rst 2 cycles -> inst_out=8'h00, start_out=0, in_ready=1, fifo_count=0, done=0.
- Basic program:
  - Stimulus: push 8'h46, 8'h9B, 8'hE7 (last on 8'hE7); then go=1.
  - inst_out sequence: 46, 9B, E7, 00, 00, each with start_out=1.
  - Then done=1, start_out=0, issued_cnt=3.
- Starvation: go=1 with an empty FIFO for 3 cycles, then push 8'h46 (last):
  - 3+ bubbles of 8'h00 with start_out=1, then 46 followed by 2 NOPs, then done.
  - With INST_FETCH_STATS_EN: bubble_cnt equals the number of empty RUN cycles (>=3).
- Full/back-pressure: push 9 entries without go -> in_ready=0 after the 8th push, the 9th is not accepted, fifo_count=8. One pop -> in_ready=1.
- Pause: deassert go for 2 cycles while in DRAIN with drain_cnt=2 -> start_out=0, inst_out held, drain_cnt frozen. Re-assert go -> exactly 2 NOPs, then DONE.
- Reset mid-RUN with 4 entries queued: assert rst -> next cycle state IDLE, fifo_count=0, start_out=0, issued_cnt=0.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction-fetch stage feeding the 4-register add/sub/and pipeline.
// Buffers pushed instructions in a FIFO and issues one per cycle on a registered
// inst_out, together with the pipeline advance enable start_out.
// When the FIFO runs dry it issues NOP bubbles. After a program's last instruction
// it issues DRAIN_CYCLES NOPs, so that the final write-back lands before done rises.
// Optional macro INST_FETCH_STATS_EN adds a saturating bubble_cnt output.
module inst_fetch_queue #(
    parameter int         DEPTH        = 8,
    parameter int         AW           = 3,
    parameter int         DRAIN_CYCLES = 2,
    parameter logic [7:0] NOP_INST     = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_inst,
    input  logic          in_last,
    output logic          in_ready,
    input  logic          go,
    output logic [7:0]    inst_out,
    output logic          start_out,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   fifo_count,
    output logic [15:0]   issued_cnt
`ifdef INST_FETCH_STATS_EN
    ,
    output logic [15:0]   bubble_cnt
`endif
);

    localparam int            DW         = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state;
    state_t         state_nxt;

    logic [8:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [DW-1:0]  drain_cnt;

    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic [7:0]     head_inst;
    logic           head_last;

    logic           start_nxt;
    logic [7:0]     inst_nxt;
    logic           load_drain;
    logic           dec_drain;

    assign fifo_empty = (fifo_count == '0);
    assign in_ready   = (fifo_count != FULL_COUNT);
    assign push       = in_valid && in_ready;
    assign head_inst  = mem[rd_ptr][7:0];
    assign head_last  = mem[rd_ptr][8];
    assign busy       = (state == RUN) || (state == DRAIN);
    assign done       = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: go=0 pauses RUN/DRAIN; the last popped entry ends the program.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (go && !fifo_empty && head_last) begin
                    state_nxt = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (go && (drain_cnt <= DW'(1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (go) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: the issue-side next values plus pop and drain-counter controls.
    always_comb begin
        pop        = 1'b0;
        start_nxt  = 1'b0;
        inst_nxt   = inst_out;
        load_drain = 1'b0;
        dec_drain  = 1'b0;
        case (state)
            RUN: begin
                if (go) begin
                    start_nxt = 1'b1;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        inst_nxt   = head_inst;
                        load_drain = head_last;
                    end else begin
                        inst_nxt = NOP_INST;
                    end
                end
            end
            DRAIN: begin
                if (go) begin
                    start_nxt = 1'b1;
                    inst_nxt  = NOP_INST;
                    dec_drain = 1'b1;
                end
            end
            DONE: begin
                inst_nxt = NOP_INST;
            end
            default: ;
        endcase
    end

    // Issue registers: instruction, advance enable, drain countdown and issue counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_out   <= NOP_INST;
            start_out  <= 1'b0;
            drain_cnt  <= '0;
            issued_cnt <= 16'd0;
        end else begin
            inst_out  <= inst_nxt;
            start_out <= start_nxt;
            if (load_drain) begin
                drain_cnt <= DRAIN_INIT;
            end else if (dec_drain) begin
                drain_cnt <= drain_cnt - DW'(1);
            end
            if (pop) begin
                issued_cnt <= issued_cnt + 16'd1;
            end
        end
    end

    // FIFO storage; unreset since occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_last, in_inst};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef INST_FETCH_STATS_EN
    // Saturating count of starved RUN cycles that issued a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= 16'd0;
        end else if ((state == RUN) && go && fifo_empty && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: table-driven, hand-sequenced and randomized checks of
// inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int         DEPTH = 8;
    localparam int         DRAIN = 2;
    localparam logic [7:0] NOP   = 8'h00;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_inst;
    logic        in_last;
    logic        in_ready;
    logic        go;
    logic [7:0]  inst_out;
    logic        start_out;
    logic        busy;
    logic        done;
    logic [3:0]  fifo_count;
    logic [15:0] issued_cnt;
`ifdef INST_FETCH_STATS_EN
    logic [15:0] bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit [8:0]    mq[$];
    int          m_phase;
    logic [7:0]  m_inst;
    logic        m_start;
    logic [15:0] m_issued;
    logic [15:0] m_bubbles;
    int          m_drain;

    typedef struct {
        logic        r;
        logic        v;
        logic [7:0]  i;
        logic        l;
        logic        g;
        logic [7:0]  e_inst;
        logic        e_start;
        logic        e_busy;
        logic        e_done;
        logic        e_ready;
        logic [3:0]  e_count;
        logic [15:0] e_issued;
    } vec_t;

    vec_t vecs[12];

    inst_fetch_queue #(
        .DEPTH(DEPTH), .AW(3), .DRAIN_CYCLES(DRAIN), .NOP_INST(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_inst    (in_inst),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .go         (go),
        .inst_out   (inst_out),
        .start_out  (start_out),
        .busy       (busy),
        .done       (done),
        .fifo_count (fifo_count),
        .issued_cnt (issued_cnt)
`ifdef INST_FETCH_STATS_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance the reference model by one clock edge using the currently driven inputs.
    task automatic modelStep();
        bit [8:0] e;
        bit       push_ok;
        if (rst) begin
            mq.delete();
            m_phase   = P_IDLE;
            m_inst    = NOP;
            m_start   = 1'b0;
            m_issued  = 16'd0;
            m_bubbles = 16'd0;
            m_drain   = 0;
        end else begin
            push_ok = in_valid && (mq.size() != DEPTH);
            case (m_phase)
                P_IDLE: begin
                    m_start = 1'b0;
                    if (go) m_phase = P_RUN;
                end
                P_RUN: begin
                    if (!go) begin
                        m_start = 1'b0;
                    end else if (mq.size() > 0) begin
                        e        = mq.pop_front();
                        m_inst   = e[7:0];
                        m_start  = 1'b1;
                        m_issued = m_issued + 16'd1;
                        if (e[8]) begin
                            if (DRAIN == 0) begin
                                m_phase = P_DONE;
                            end else begin
                                m_phase = P_DRAIN;
                                m_drain = DRAIN;
                            end
                        end
                    end else begin
                        m_inst  = NOP;
                        m_start = 1'b1;
                        if (m_bubbles != 16'hFFFF) m_bubbles = m_bubbles + 16'd1;
                    end
                end
                P_DRAIN: begin
                    if (!go) begin
                        m_start = 1'b0;
                    end else begin
                        m_inst  = NOP;
                        m_start = 1'b1;
                        if (m_drain == 1) m_phase = P_DONE;
                        m_drain = m_drain - 1;
                    end
                end
                default: begin
                    m_start = 1'b0;
                    m_inst  = NOP;
                    if (go) m_phase = P_RUN;
                end
            endcase
            if (push_ok) mq.push_back({in_last, in_inst});
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] i,
                                 input logic l, input logic g);
        rst      = r;
        in_valid = v;
        in_inst  = i;
        in_last  = l;
        go       = g;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("model inst_out", {8'h00, inst_out}, {8'h00, m_inst});
        checkOutput("model start_out", {15'd0, start_out}, {15'd0, m_start});
        checkOutput("model busy", {15'd0, busy},
                    {15'd0, (m_phase == P_RUN) || (m_phase == P_DRAIN)});
        checkOutput("model done", {15'd0, done}, {15'd0, m_phase == P_DONE});
        checkOutput("model fifo_count", {12'd0, fifo_count}, 16'(mq.size()));
        checkOutput("model in_ready", {15'd0, in_ready}, {15'd0, mq.size() != DEPTH});
        checkOutput("model issued_cnt", issued_cnt, m_issued);
`ifdef INST_FETCH_STATS_EN
        checkOutput("model bubble_cnt", bubble_cnt, m_bubbles);
`endif
    endtask

    task automatic stepAndCheck(input logic r, input logic v, input logic [7:0] i,
                                input logic l, input logic g);
        applyStimulus(r, v, i, l, g);
        checkModel();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst = 8'h00; in_last = 1'b0; go = 1'b0;

        // Reset, basic 3-instruction program, drain, done
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 8'h46, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 16'd0};
        vecs[3]  = '{1'b0, 1'b1, 8'h9B, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 16'd0};
        vecs[4]  = '{1'b0, 1'b1, 8'hE7, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 16'd0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 16'd0};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h46, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 16'd1};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h9B, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 16'd2};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hE7, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 16'd3};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 16'd3};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 16'd3};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 16'd3};

        for (int k = 0; k < 12; k++) begin
            applyStimulus(vecs[k].r, vecs[k].v, vecs[k].i, vecs[k].l, vecs[k].g);
            checkOutput($sformatf("vec%0d inst_out", k), {8'h00, inst_out}, {8'h00, vecs[k].e_inst});
            checkOutput($sformatf("vec%0d start_out", k), {15'd0, start_out}, {15'd0, vecs[k].e_start});
            checkOutput($sformatf("vec%0d busy", k), {15'd0, busy}, {15'd0, vecs[k].e_busy});
            checkOutput($sformatf("vec%0d done", k), {15'd0, done}, {15'd0, vecs[k].e_done});
            checkOutput($sformatf("vec%0d in_ready", k), {15'd0, in_ready}, {15'd0, vecs[k].e_ready});
            checkOutput($sformatf("vec%0d fifo_count", k), {12'd0, fifo_count}, {12'd0, vecs[k].e_count});
            checkOutput($sformatf("vec%0d issued_cnt", k), issued_cnt, vecs[k].e_issued);
            checkModel();
        end

        // Starvation: 4 bubbles (the push edge itself is still empty), then 46 and 2 NOPs
        stepAndCheck(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        stepAndCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            stepAndCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            checkOutput("starve bubble inst", {8'h00, inst_out}, 16'h0000);
            checkOutput("starve bubble start", {15'd0, start_out}, 16'd1);
        end
        stepAndCheck(1'b0, 1'b1, 8'h46, 1'b1, 1'b1);
        stepAndCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("starve issue 46", {8'h00, inst_out}, 16'h0046);
        stepAndCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        stepAndCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("starve done", {15'd0, done}, 16'd1);
`ifdef INST_FETCH_STATS_EN
        checkOutput("starve bubble_cnt", bubble_cnt, 16'd4);
`endif

        // Full / back-pressure: 9 pushes without go
        stepAndCheck(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            stepAndCheck(1'b0, 1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
        end
        checkOutput("full count", {12'd0, fifo_count}, 16'd8);
        checkOutput("full in_ready", {15'd0, in_ready}, 16'd0);
        stepAndCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        stepAndCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("full pop inst", {8'h00, inst_out}, 16'h0010);
        checkOutput("full pop count", {12'd0, fifo_count}, 16'd7);
        checkOutput("full pop in_ready", {15'd0, in_ready}, 16'd1);

        // Pause during drain: hold 2 cycles, then exactly 2 NOPs and done
        stepAndCheck(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        stepAndCheck(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
        stepAndCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        stepAndCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("drain issue A5", {8'h00, inst_out}, 16'h00A5);
        for (int k = 0; k < 2; k++) begin
            stepAndCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            checkOutput("pause start", {15'd0, start_out}, 16'd0);
            checkOutput("pause inst held", {8'h00, inst_out}, 16'h00A5);
            checkOutput("pause busy", {15'd0, busy}, 16'd1);
        end
        stepAndCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("resume nop1 done", {15'd0, done}, 16'd0);
        stepAndCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("resume nop2 start", {15'd0, start_out}, 16'd1);
        checkOutput("resume nop2 done", {15'd0, done}, 16'd1);
        stepAndCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("done start low", {15'd0, start_out}, 16'd0);

        // Reset mid-RUN with 4 entries queued
        stepAndCheck(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            stepAndCheck(1'b0, 1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
        end
        stepAndCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        stepAndCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("midrun count", {12'd0, fifo_count}, 16'd4);
        stepAndCheck(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("midrun rst count", {12'd0, fifo_count}, 16'd0);
        checkOutput("midrun rst start", {15'd0, start_out}, 16'd0);
        checkOutput("midrun rst issued", issued_cnt, 16'd0);
        checkOutput("midrun rst busy", {15'd0, busy}, 16'd0);

        // Randomized traffic against the reference model
        stepAndCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 600; k++) begin
            stepAndCheck($urandom_range(0, 99) == 0,
                         $urandom_range(0, 9) < 6,
                         8'($urandom),
                         $urandom_range(0, 4) == 0,
                         $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
